// File: rtl/axi_mem_slv_if.sv
// AXI4 channel bundle between a master-side driver and the axi_mem_slv responder.
interface axi_mem_slv_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4
) ();
  localparam int unsigned STRB = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic [5:0]            aw_atop;
  logic                  aw_valid;
  logic                  aw_ready;

  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB-1:0]       w_strb;
  logic                  w_last;
  logic                  w_valid;
  logic                  w_ready;

  logic [ID_WIDTH-1:0]   b_id;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;

  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  ar_valid;
  logic                  ar_ready;

  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic                  r_valid;
  logic                  r_ready;

  modport slv (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_atop, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );

  modport mst (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_atop, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );
endinterface

// File: rtl/axi_mem_slv.sv
// AXI4 memory responder: one write and one read burst in flight, FIXED/INCR,
// byte-strobed storage, OKAY/SLVERR/DECERR responses.
module axi_mem_slv #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           ID_WIDTH   = 4,
  parameter int unsigned           MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic        clk,
  input logic        rst_n,
  axi_mem_slv_if.slv bus
);
  localparam int unsigned STRB  = DATA_WIDTH / 8;
  localparam int unsigned OFFS  = $clog2(STRB);
  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic burst_ok(input logic [1:0] burst, input logic [2:0] size);
    return (burst == BURST_FIXED || burst == BURST_INCR) && (32'(size) <= OFFS);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] size_step(input logic [2:0] size);
    return ADDR_WIDTH'(1) << size;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] align(input logic [ADDR_WIDTH-1:0] addr,
                                                  input logic [2:0] size);
    return addr & ~(size_step(size) - ADDR_WIDTH'(1));
  endfunction

  // Borrow out of the base subtraction flags addresses below BASE_ADDR.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return !off[ADDR_WIDTH] && ((off[ADDR_WIDTH-1:0] >> OFFS) < ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> OFFS);
  endfunction

  // ---------------- write path ----------------
  w_state_e              w_state_q;
  logic                  aw_ready_q, w_ready_q, b_valid_q;
  logic [ID_WIDTH-1:0]   b_id_q;
  logic [1:0]            b_resp_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]            wlen_q, wcnt_q;
  logic [2:0]            wsize_q;
  logic [1:0]            wburst_q;
  logic                  wlegal_q, wslv_q, wdec_q;

  logic             wbeat_c, w_inr_c, mem_we_c, w_last_err_c, aw_legal_c;
  logic [IDX_W-1:0] w_idx_c;

  assign aw_legal_c   = burst_ok(bus.aw_burst, bus.aw_size) && (bus.aw_atop == 6'd0);
  assign wbeat_c      = (w_state_q == W_DATA) && bus.w_valid && w_ready_q;
  assign w_inr_c      = in_range(waddr_q);
  assign w_idx_c      = word_idx(waddr_q);
  assign mem_we_c     = wbeat_c && wlegal_q && w_inr_c;
  assign w_last_err_c = bus.w_last ? (wcnt_q != wlen_q) : (wcnt_q == wlen_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= RESP_OKAY;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wcnt_q     <= '0;
      wsize_q    <= '0;
      wburst_q   <= '0;
      wlegal_q   <= 1'b0;
      wslv_q     <= 1'b0;
      wdec_q     <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          aw_ready_q <= 1'b1;
          if (bus.aw_valid && aw_ready_q) begin
            b_id_q     <= bus.aw_id;
            waddr_q    <= align(bus.aw_addr, bus.aw_size);
            wlen_q     <= bus.aw_len;
            wsize_q    <= bus.aw_size;
            wburst_q   <= bus.aw_burst;
            wlegal_q   <= aw_legal_c;
            wslv_q     <= !aw_legal_c;
            wdec_q     <= 1'b0;
            wcnt_q     <= '0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            w_state_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (wbeat_c) begin
            wcnt_q <= wcnt_q + 8'd1;
            if (wburst_q == BURST_INCR) waddr_q <= waddr_q + size_step(wsize_q);
            if (!w_inr_c)     wdec_q <= 1'b1;
            if (w_last_err_c) wslv_q <= 1'b1;
            if (bus.w_last) begin
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              b_resp_q  <= (wslv_q || w_last_err_c) ? RESP_SLVERR :
                           (wdec_q || !w_inr_c)     ? RESP_DECERR : RESP_OKAY;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bus.b_ready) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_state_q  <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < STRB; b++) begin
        if (bus.w_strb[b]) mem[w_idx_c][8*b +: 8] <= bus.w_data[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_e              r_state_q;
  logic                  ar_ready_q, r_valid_q, r_last_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [1:0]            r_resp_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [7:0]            rlen_q, rcnt_q;
  logic [2:0]            rsize_q;
  logic [1:0]            rburst_q;
  logic                  rlegal_q;

  logic                  r_start_c, r_adv_c, rd_legal_c, rd_inr_c, rd_last_c;
  logic [ADDR_WIDTH-1:0] rd_addr_c;
  logic [IDX_W-1:0]      rd_idx_c;
  logic [1:0]            rd_resp_c;

  assign r_start_c = (r_state_q == R_IDLE) && bus.ar_valid && ar_ready_q;
  assign r_adv_c   = (r_state_q == R_DATA) && r_valid_q && bus.r_ready && !r_last_q;

  // Address, legality and last-flag of the beat about to be presented.
  always_comb begin
    rd_addr_c  = raddr_q;
    rd_legal_c = rlegal_q;
    rd_last_c  = (8'(rcnt_q + 8'd1) == rlen_q);
    if (r_start_c) begin
      rd_addr_c  = align(bus.ar_addr, bus.ar_size);
      rd_legal_c = burst_ok(bus.ar_burst, bus.ar_size);
      rd_last_c  = (bus.ar_len == 8'd0);
    end else if (rburst_q == BURST_INCR) begin
      rd_addr_c  = raddr_q + size_step(rsize_q);
    end
  end

  assign rd_inr_c  = in_range(rd_addr_c);
  assign rd_idx_c  = word_idx(rd_addr_c);
  assign rd_resp_c = !rd_legal_c ? RESP_SLVERR : (!rd_inr_c ? RESP_DECERR : RESP_OKAY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rcnt_q     <= '0;
      rsize_q    <= '0;
      rburst_q   <= '0;
      rlegal_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          ar_ready_q <= 1'b1;
          if (r_start_c) begin
            ar_ready_q <= 1'b0;
            r_id_q     <= bus.ar_id;
            rlen_q     <= bus.ar_len;
            rsize_q    <= bus.ar_size;
            rburst_q   <= bus.ar_burst;
            rlegal_q   <= rd_legal_c;
            r_valid_q  <= 1'b1;
            r_state_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_valid_q && bus.r_ready && r_last_q) begin
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
            r_state_q  <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
      if (r_start_c || r_adv_c) begin
        raddr_q  <= rd_addr_c;
        rcnt_q   <= r_start_c ? 8'd0 : 8'(rcnt_q + 8'd1);
        r_last_q <= rd_last_c;
        r_resp_q <= rd_resp_c;
        r_data_q <= (rd_resp_c == RESP_OKAY) ? mem[rd_idx_c] : '0;
      end
    end
  end

  assign bus.aw_ready = aw_ready_q;
  assign bus.w_ready  = w_ready_q;
  assign bus.b_valid  = b_valid_q;
  assign bus.b_id     = b_id_q;
  assign bus.b_resp   = b_resp_q;
  assign bus.ar_ready = ar_ready_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.r_id     = r_id_q;
  assign bus.r_data   = r_data_q;
  assign bus.r_resp   = r_resp_q;
  assign bus.r_last   = r_last_q;
endmodule

// File: tb/tb_axi_mem_slv.sv
// Bench for axi_mem_slv: directed and random bursts checked against a
// byte-level memory model that applies the addressing/response rules directly.
module tb_axi_mem_slv;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 64;
  localparam int unsigned IW    = 4;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_mem_slv_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_mem_slv #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mdl [DEPTH];
  logic [63:0] wd [$];
  logic [7:0]  ws [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit mem_hit(input logic [31:0] a, output int unsigned idx);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE};
    idx = int'(off[31:3]);
    return !off[32] && (off[31:3] < 29'(DEPTH));
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst, input int i);
    logic [31:0] step;
    logic [31:0] a0;
    step = 32'd1 << size;
    a0   = addr & ~(step - 32'd1);
    return (burst == 2'b01) ? a0 + step * 32'(i) : a0;
  endfunction

  // Applies a write burst of nbeats (queued in wd/ws) to the model and returns B.
  task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [5:0] atop, input int nbeats,
                             output logic [1:0] resp);
    bit legal, slv, dec;
    int unsigned idx;
    legal = (burst == 2'b00 || burst == 2'b01) && (size <= 3'd3) && (atop == 6'd0);
    slv   = !legal || (nbeats != int'(len) + 1);
    dec   = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (!mem_hit(beat_addr(addr, size, burst, i), idx)) dec = 1'b1;
      else if (legal) begin
        for (int b = 0; b < 8; b++)
          if (ws[i][b]) mdl[idx][8*b +: 8] = wd[i][8*b +: 8];
      end
    end
    resp = slv ? 2'b10 : (dec ? 2'b11 : 2'b00);
  endtask

  task automatic model_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int i,
                            output logic [63:0] d, output logic [1:0] resp, output logic last);
    bit legal, inr;
    int unsigned idx;
    legal = (burst == 2'b00 || burst == 2'b01) && (size <= 3'd3);
    inr   = mem_hit(beat_addr(addr, size, burst, i), idx);
    resp  = !legal ? 2'b10 : (!inr ? 2'b11 : 2'b00);
    d     = (resp == 2'b00) ? mdl[idx] : 64'd0;
    last  = (i == int'(len));
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [5:0] atop,
                          input int nbeats, input int bhold);
    logic [1:0] eresp;
    bit hs;
    int t;
    model_write(addr, len, size, burst, atop, nbeats, eresp);
    bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_size = size;
    bus.aw_burst = burst; bus.aw_atop = atop; bus.aw_valid = 1'b1;
    bus.w_data = wd[0]; bus.w_strb = ws[0]; bus.w_last = (nbeats == 1); bus.w_valid = 1'b1;
    hs = 1'b0; t = 0;
    while (!hs && t < 50) begin
      @(negedge clk);
      check("w_ready_before_aw", bus.w_ready, 1'b0);
      hs = bus.aw_ready;
      @(posedge clk); #1; t++;
    end
    check("aw_handshake", hs, 1'b1);
    bus.aw_valid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.w_data = wd[i]; bus.w_strb = ws[i]; bus.w_last = (i == nbeats - 1); bus.w_valid = 1'b1;
      hs = 1'b0; t = 0;
      while (!hs && t < 50) begin
        @(negedge clk); hs = bus.w_ready;
        @(posedge clk); #1; t++;
      end
      check("w_handshake", hs, 1'b1);
      bus.w_valid = 1'b0; bus.w_last = 1'b0;
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    hs = 1'b0; t = 0;
    while (!hs && t < 50) begin
      @(negedge clk); hs = bus.b_valid;
      if (!hs) begin @(posedge clk); #1; t++; end
    end
    check("b_valid", hs, 1'b1);
    check("b_id", bus.b_id, id);
    check("b_resp", bus.b_resp, eresp);
    for (int k = 0; k < bhold; k++) begin
      @(posedge clk); #1; @(negedge clk);
      check("b_hold_valid", bus.b_valid, 1'b1);
      check("b_hold_id", bus.b_id, id);
      check("b_hold_resp", bus.b_resp, eresp);
    end
    bus.b_ready = 1'b1;
    @(posedge clk); #1;
    bus.b_ready = 1'b0;
    @(negedge clk);
    check("aw_ready_after_b", bus.aw_ready, 1'b1);
    check("b_valid_dropped", bus.b_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  // mode: 0 constant r_ready, 1 toggling r_ready, 2 random r_ready.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int mode,
                         input bit chk_lat);
    logic [63:0] ed;
    logic [1:0]  er;
    logic        el;
    bit hs;
    int t, beats, cyc, prev;
    bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_size = size;
    bus.ar_burst = burst; bus.ar_valid = 1'b1;
    hs = 1'b0; t = 0;
    while (!hs && t < 50) begin
      @(negedge clk); hs = bus.ar_ready;
      @(posedge clk); #1; t++;
    end
    check("ar_handshake", hs, 1'b1);
    bus.ar_valid = 1'b0;
    beats = 0; cyc = 0; prev = 0;
    while (beats <= int'(len) && cyc < 64 + 4 * int'(len)) begin
      if (mode == 0)      bus.r_ready = 1'b1;
      else if (mode == 1) bus.r_ready = (cyc % 2 == 1);
      else                bus.r_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (chk_lat && cyc == 0) check("r_valid_latency", bus.r_valid, 1'b1);
      if (bus.r_valid && bus.r_ready) begin
        model_read(addr, len, size, burst, beats, ed, er, el);
        check($sformatf("r_data[%0d]", beats), bus.r_data, ed);
        check($sformatf("r_resp[%0d]", beats), bus.r_resp, er);
        check($sformatf("r_last[%0d]", beats), bus.r_last, el);
        check($sformatf("r_id[%0d]", beats), bus.r_id, id);
        if (mode == 0 && beats > 0) check("r_back_to_back", 64'(cyc - prev), 64'd1);
        prev = cyc; beats++;
      end
      @(posedge clk); #1; cyc++;
    end
    check("r_beat_count", 64'(beats), 64'(int'(len) + 1));
    bus.r_ready = 1'b0;
    @(negedge clk);
    check("ar_ready_after_r", bus.ar_ready, 1'b1);
    check("r_valid_dropped", bus.r_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a_d, b_d, c_d, d_d;
    logic [3:0]  rid;
    logic [31:0] raddr;
    logic [7:0]  rlen;
    logic [2:0]  rsize;
    logic [1:0]  rburst;
    logic [5:0]  ratop;
    int          rsel, nb;

    bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
    bus.aw_atop = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_valid = 1'b0;
    bus.b_ready = 1'b0;
    bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
    bus.ar_valid = 1'b0; bus.r_ready = 1'b0;

    // Reset values and first-edge ready rise.
    repeat (3) @(negedge clk);
    check("rst_aw_ready", bus.aw_ready, 1'b0);
    check("rst_ar_ready", bus.ar_ready, 1'b0);
    check("rst_w_ready", bus.w_ready, 1'b0);
    check("rst_b_valid", bus.b_valid, 1'b0);
    check("rst_r_valid", bus.r_valid, 1'b0);
    rst_n = 1'b1;
    #1 check("aw_ready_before_edge", bus.aw_ready, 1'b0);
    @(posedge clk); #1;
    check("aw_ready_first_edge", bus.aw_ready, 1'b1);
    check("ar_ready_first_edge", bus.ar_ready, 1'b1);

    // Fill the whole memory so every later read has a defined model value.
    for (int k = 0; k < 4; k++) begin
      wd.delete(); ws.delete();
      for (int i = 0; i < 256; i++) begin wd.push_back({$urandom, $urandom}); ws.push_back(8'hFF); end
      do_write(4'(k), 32'(k * 2048), 8'd255, 3'd3, 2'b01, 6'd0, 256, 0);
    end

    // Single write, read back with latency check.
    wd.delete(); ws.delete(); wd.push_back(64'h1122334455667788); ws.push_back(8'hFF);
    do_write(4'd5, 32'h10, 8'd0, 3'd3, 2'b01, 6'd0, 1, 0);
    do_read(4'd2, 32'h10, 8'd0, 3'd3, 2'b01, 0, 1'b1);

    // INCR with a half-strobed beat over an all-ones word.
    wd.delete(); ws.delete(); wd.push_back(64'hFFFF_FFFF_FFFF_FFFF); ws.push_back(8'hFF);
    do_write(4'd1, 32'h110, 8'd0, 3'd3, 2'b01, 6'd0, 1, 0);
    a_d = 64'hA0A1A2A3A4A5A6A7; b_d = 64'hB0B1B2B3B4B5B6B7;
    c_d = 64'hC0C1C2C3C4C5C6C7; d_d = 64'hD0D1D2D3D4D5D6D7;
    wd.delete(); ws.delete();
    wd.push_back(a_d); wd.push_back(b_d); wd.push_back(c_d); wd.push_back(d_d);
    ws.push_back(8'hFF); ws.push_back(8'hFF); ws.push_back(8'h0F); ws.push_back(8'hFF);
    do_write(4'd3, 32'h100, 8'd3, 3'd3, 2'b01, 6'd0, 4, 0);
    do_read(4'd3, 32'h100, 8'd3, 3'd3, 2'b01, 0, 1'b1);

    // FIXED burst: last beat wins.
    wd.delete(); ws.delete();
    for (int i = 1; i <= 4; i++) begin wd.push_back(64'(i)); ws.push_back(8'hFF); end
    do_write(4'd6, 32'h40, 8'd3, 3'd3, 2'b00, 6'd0, 4, 0);
    do_read(4'd6, 32'h40, 8'd0, 3'd3, 2'b01, 0, 1'b0);

    // Top-of-memory straddle: DECERR on beat 1.
    wd.delete(); ws.delete();
    wd.push_back(64'h0123456789ABCDEF); wd.push_back(64'hFEDCBA9876543210);
    ws.push_back(8'hFF); ws.push_back(8'hFF);
    do_write(4'd7, BASE + 32'(DEPTH * 8) - 32'd8, 8'd1, 3'd3, 2'b01, 6'd0, 2, 0);
    do_read(4'd7, BASE + 32'(DEPTH * 8) - 32'd8, 8'd1, 3'd3, 2'b01, 0, 1'b0);

    // SLVERR cases.
    wd.delete(); ws.delete();
    for (int i = 0; i < 4; i++) begin wd.push_back({$urandom, $urandom}); ws.push_back(8'hFF); end
    do_write(4'd8, 32'h300, 8'd3, 3'd3, 2'b10, 6'd0, 4, 0);
    do_read(4'd8, 32'h300, 8'd3, 3'd3, 2'b01, 0, 1'b0);
    do_write(4'd9, 32'h340, 8'd1, 3'd4, 2'b01, 6'd0, 2, 0);
    do_read(4'd9, 32'h340, 8'd1, 3'd3, 2'b01, 0, 1'b0);
    do_write(4'd10, 32'h380, 8'd0, 3'd3, 2'b01, 6'h20, 1, 0);
    do_read(4'd10, 32'h380, 8'd0, 3'd3, 2'b01, 0, 1'b0);
    do_write(4'd11, 32'h3C0, 8'd3, 3'd3, 2'b01, 6'd0, 2, 0);
    do_read(4'd11, 32'h3C0, 8'd3, 3'd3, 2'b01, 0, 1'b0);
    do_read(4'd12, 32'h340, 8'd1, 3'd4, 2'b01, 0, 1'b0);

    // B backpressure and R toggling.
    wd.delete(); ws.delete(); wd.push_back({$urandom, $urandom}); ws.push_back(8'h5A);
    do_write(4'd13, 32'h500, 8'd0, 3'd3, 2'b01, 6'd0, 1, 5);
    do_read(4'd14, 32'h500, 8'd15, 3'd3, 2'b01, 1, 1'b0);

    // Reset in the middle of a read burst.
    bus.ar_id = 4'd4; bus.ar_addr = 32'h200; bus.ar_len = 8'd7; bus.ar_size = 3'd3;
    bus.ar_burst = 2'b01; bus.ar_valid = 1'b1; bus.r_ready = 1'b1;
    @(negedge clk); check("mid_ar_ready", bus.ar_ready, 1'b1);
    @(posedge clk); #1; bus.ar_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("mid_r_valid_before_rst", bus.r_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_r_valid_async", bus.r_valid, 1'b0);
    check("mid_ar_ready_rst", bus.ar_ready, 1'b0);
    bus.r_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_ar_ready_released", bus.ar_ready, 1'b0);
    @(posedge clk); #1;
    check("mid_ar_ready_edge", bus.ar_ready, 1'b1);
    check("mid_aw_ready_edge", bus.aw_ready, 1'b1);
    do_read(4'd4, 32'h200, 8'd7, 3'd3, 2'b01, 0, 1'b1);

    // Randomized write/read pairs.
    for (int n = 0; n < 40; n++) begin
      rid  = 4'($urandom);
      rlen = 8'($urandom_range(0, 7));
      rsize = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      rsel = $urandom_range(0, 9);
      rburst = (rsel < 5) ? 2'b01 : (rsel < 8) ? 2'b00 : (rsel == 8) ? 2'b10 : 2'b11;
      ratop = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      raddr = ($urandom_range(0, 3) == 0) ? 32'h1F00 + 32'($urandom_range(0, 511))
                                          : 32'($urandom_range(0, 32'h1FFF));
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, int'(rlen) + 1) : int'(rlen) + 1;
      wd.delete(); ws.delete();
      for (int i = 0; i < nb; i++) begin
        wd.push_back({$urandom, $urandom}); ws.push_back(8'($urandom));
      end
      do_write(rid, raddr, rlen, rsize, rburst, ratop, nb, $urandom_range(0, 3));
      do_read(~rid, raddr, rlen, rsize, rburst, $urandom_range(0, 2), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
